lag_link_input_buffer: RTL and testbench

Router input-side link buffer for one physical channel. Sits directly downstream of the pipelined channel and upstream of the one-hot-select crossbar. Captures flits arriving off the link into a small FIFO and presents the head flit to the crossbar input. Returns one credit per dequeued flit to the upstream sender and flags any flow-control violation.

---
 rtl/lag_link_input_buffer_pkg.sv | 27 ++
 rtl/lag_link_buffer_mem.sv | 24 ++
 rtl/lag_link_input_buffer.sv | 81 ++++++++
 tb/tb_lag_link_input_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lag_link_input_buffer_pkg.sv
// Shared LAG router types: flit and channel-control payloads, link buffer defaults,
// and the modulo pointer increment used by the input-side buffers.
package lag_link_input_buffer_pkg;

  localparam int unsigned LAG_LINK_BUF_DEPTH_DEFAULT = 4;
  localparam int unsigned LAG_PTR_W                  = 4;

  typedef struct packed {
    logic        head;
    logic        tail;
    logic [3:0]  dest;
    logic [25:0] data;
  } flit_t;

  typedef struct packed {
    logic       credit;
    logic [3:0] vc;
  } chan_cntrl_t;

  // Wrap at depth-1 with an explicit compare so non-power-of-two depths work.
  function automatic logic [LAG_PTR_W-1:0] lag_ptr_inc(input logic [LAG_PTR_W-1:0] ptr,
                                                       input int unsigned          depth);
    if (32'(ptr) == depth - 32'd1) return '0;
    return ptr + LAG_PTR_W'(1);
  endfunction

endpackage

// File: rtl/lag_link_buffer_mem.sv
// Flit storage for the link buffer: one synchronous write port, one async read port.
module lag_link_buffer_mem
  import lag_link_input_buffer_pkg::*;
#(
  parameter int unsigned depth = LAG_LINK_BUF_DEPTH_DEFAULT,
  parameter int unsigned aw    = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  flit_t         wdata,
  input  logic [aw-1:0] raddr,
  output flit_t         rdata
);

  flit_t r_mem [depth];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/lag_link_input_buffer.sv
// Router input link buffer: captures flits off the channel, presents the head flit
// to the crossbar, returns one credit per dequeue and flags flow-control violations.
module lag_link_input_buffer
  import lag_link_input_buffer_pkg::*;
#(
  parameter  int unsigned depth = LAG_LINK_BUF_DEPTH_DEFAULT,
  localparam int unsigned cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  flit_t            data_in,
  input  logic             valid_in,
  output flit_t            data_out,
  output logic             valid_out,
  input  logic             deq,
  output logic             credit_out,
  output logic [cnt_w-1:0] occupancy,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;

  logic [LAG_PTR_W-1:0] r_wr_ptr;
  logic [LAG_PTR_W-1:0] r_rd_ptr;
  logic [cnt_w-1:0]     r_occ;
  logic                 r_credit;
  logic                 r_ovf;
  logic                 r_udf;

  logic  w_empty;
  logic  w_full;
  logic  w_deq_ok;
  logic  w_wr;
  flit_t w_rdata;

  assign w_empty  = (r_occ == '0);
  assign w_full   = (r_occ == cnt_w'(depth));
  assign w_deq_ok = deq && !w_empty;
  // A full buffer still accepts when the same-cycle dequeue frees the head slot.
  assign w_wr     = valid_in && (!w_full || w_deq_ok);

  lag_link_buffer_mem #(
    .depth (depth),
    .aw    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr),
    .waddr (AW'(r_wr_ptr)),
    .wdata (data_in),
    .raddr (AW'(r_rd_ptr)),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr)     r_wr_ptr <= lag_ptr_inc(r_wr_ptr, depth);
      if (w_deq_ok) r_rd_ptr <= lag_ptr_inc(r_rd_ptr, depth);
      if (w_wr && !w_deq_ok)      r_occ <= r_occ + cnt_w'(1);
      else if (!w_wr && w_deq_ok) r_occ <= r_occ - cnt_w'(1);
      r_credit <= w_deq_ok;
      if (valid_in && w_full && !w_deq_ok) r_ovf <= 1'b1;
      if (deq && w_empty)                  r_udf <= 1'b1;
    end
  end

  assign valid_out     = !w_empty;
  assign data_out      = w_empty ? '0 : w_rdata;
  assign occupancy     = r_occ;
  assign credit_out    = r_credit;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_udf;

endmodule

// File: tb/tb_lag_link_input_buffer.sv
// Directed self-checking bench for lag_link_input_buffer: a depth-4 instance for
// fill/overflow/underflow/reset cases and a depth-3 instance for pointer wrap.
module tb_lag_link_input_buffer;
  import lag_link_input_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flit_t      di4, do4;
  logic       vi4, vo4, dq4, cr4, ovf4, udf4;
  logic [2:0] occ4;

  flit_t      di3, do3;
  logic       vi3, vo3, dq3, cr3, ovf3, udf3;
  logic [1:0] occ3;

  lag_link_input_buffer #(.depth(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(di4), .valid_in(vi4), .data_out(do4),
    .valid_out(vo4), .deq(dq4), .credit_out(cr4), .occupancy(occ4),
    .overflow_err(ovf4), .underflow_err(udf4)
  );

  lag_link_input_buffer #(.depth(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(di3), .valid_in(vi3), .data_out(do3),
    .valid_out(vo3), .deq(dq3), .credit_out(cr3), .occupancy(occ3),
    .overflow_err(ovf3), .underflow_err(udf3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after return take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(input int n);
    return flit_t'(32'hC000_0000 | 32'(n));
  endfunction

  task automatic push4(input flit_t f);
    vi4 = 1'b1; di4 = f;
    step();
    vi4 = 1'b0; di4 = '0;
  endtask

  flit_t A, B, C, D, E, F, G;
  flit_t exp_q[4];
  int    credits;

  initial begin
    A = mk(1); B = mk(2); C = mk(3); D = mk(4); E = mk(5); F = mk(6); G = mk(7);
    vi4 = 0; dq4 = 0; di4 = '0;
    vi3 = 0; dq3 = 0; di3 = '0;
    step(); step();
    rst_n = 1'b1;

    // Reset state and idle
    chk("rst_occ", 32'(occ4), 0);
    chk("rst_valid", 32'(vo4), 0);
    chk("rst_data", 32'(do4), 0);
    chk("rst_credit", 32'(cr4), 0);
    chk("rst_errs", {30'd0, ovf4, udf4}, 0);

    push4(A);
    chk("wrA_valid", 32'(vo4), 1);
    chk("wrA_data", 32'(do4), 32'(A));
    chk("wrA_occ", 32'(occ4), 1);

    // Fill and overflow
    push4(B); push4(C); push4(D);
    chk("full_occ", 32'(occ4), 4);
    push4(E);
    chk("ovf_flag", 32'(ovf4), 1);
    chk("ovf_occ", 32'(occ4), 4);
    chk("ovf_head", 32'(do4), 32'(A));

    // Clean restart, refill, then write+deq while full
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst2_ovf", 32'(ovf4), 0);
    push4(A); push4(B); push4(C); push4(D);
    vi4 = 1'b1; di4 = F; dq4 = 1'b1;
    step();
    vi4 = 1'b0; dq4 = 1'b0;
    chk("fulldeq_occ", 32'(occ4), 4);
    chk("fulldeq_ovf", 32'(ovf4), 0);
    chk("fulldeq_udf", 32'(udf4), 0);
    chk("fulldeq_head", 32'(do4), 32'(B));
    chk("fulldeq_credit", 32'(cr4), 1);
    step();
    chk("credit_drop", 32'(cr4), 0);

    exp_q[0] = B; exp_q[1] = C; exp_q[2] = D; exp_q[3] = F;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(do4), 32'(exp_q[i]));
      dq4 = 1'b1;
      step();
      dq4 = 1'b0;
      chk($sformatf("drain_cr%0d", i), 32'(cr4), 1);
    end
    chk("drained_occ", 32'(occ4), 0);
    chk("drained_valid", 32'(vo4), 0);
    chk("drained_data", 32'(do4), 0);

    // Underflow
    step();
    dq4 = 1'b1;
    step();
    dq4 = 1'b0;
    chk("udf_flag", 32'(udf4), 1);
    chk("udf_occ", 32'(occ4), 0);
    chk("udf_credit", 32'(cr4), 0);
    dq4 = 1'b1; vi4 = 1'b1; di4 = G;
    step();
    dq4 = 1'b0; vi4 = 1'b0;
    chk("udfG_occ", 32'(occ4), 1);
    chk("udfG_data", 32'(do4), 32'(G));
    chk("udfG_credit", 32'(cr4), 0);

    // Mid-operation reset with occupancy 3 and credit pending
    push4(A); push4(B);
    vi4 = 1'b1; di4 = C; dq4 = 1'b1;
    step();
    vi4 = 1'b0; dq4 = 1'b0;
    chk("pre_rst_occ", 32'(occ4), 3);
    chk("pre_rst_credit", 32'(cr4), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_occ", 32'(occ4), 0);
    chk("midrst_valid", 32'(vo4), 0);
    chk("midrst_credit", 32'(cr4), 0);
    chk("midrst_errs", {30'd0, ovf4, udf4}, 0);
    chk("midrst_data", 32'(do4), 0);

    // Depth-3 wrap: 10 flits, deq every cycle after the first
    credits = 0;
    for (int k = 0; k < 10; k++) begin
      vi3 = 1'b1; di3 = mk(100 + k); dq3 = (k > 0);
      if (k > 0) chk($sformatf("wrap_head%0d", k), 32'(do3), 32'(mk(100 + k - 1)));
      step();
      chk($sformatf("wrap_occ%0d", k), 32'(occ3), 1);
      if (cr3) credits++;
    end
    vi3 = 1'b0; dq3 = 1'b0; di3 = '0;
    step();
    chk("wrap_credit_end", 32'(cr3), 0);
    chk("wrap_credits", 32'(credits), 9);
    chk("wrap_last", 32'(do3), 32'(mk(109)));
    chk("wrap_errs", {30'd0, ovf3, udf3}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
